cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have a single parameter line: BEATS, default 4, number of 64-bit beats per 256-bit cache line (fixed at 4 in this revision).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port line_i, input, 256, the dirty line from the cache datapath for a writeback.
REQ-005 The block SHALL have port line_o, output, 256, the assembled line returned to the cache datapath on a fill.
REQ-006 The block SHALL have port address_i, input, 32, the cache-side physical line address.
REQ-007 The block SHALL have port read_i, input, 1, the cache line-fill request (cache pmem_read).
REQ-008 The block SHALL have port write_i, input, 1, the cache writeback request (cache pmem_write).
REQ-009 The block SHALL have port resp_o, output, 1, the single-cycle line-complete pulse (cache pmem_resp).
REQ-010 The block SHALL have port burst_i, input, 64, the memory read beat.
REQ-011 The block SHALL have port burst_o, output, 64, the memory write beat.
REQ-012 The block SHALL have port address_o, output, 32, the memory burst address.
REQ-013 The block SHALL have port read_o, input-to-memory output, 1, the burst read request.
REQ-014 The block SHALL have port write_o, output, 1, the burst write request.
REQ-015 The block SHALL have port resp_i, input, 1, the memory beat-valid/beat-accepted strobe.

Function
REQ-016 FSM states SHALL be IDLE, RD_BURST, WR_BURST and DONE.
REQ-017 In IDLE with write_i=1, the block SHALL latch address_i and line_i, clear the beat counter, and go to WR_BURST; write SHALL have priority when read_i and write_i are both 1.
REQ-018 In IDLE with read_i=1 and write_i=0, the block SHALL latch address_i, clear the beat counter, and go to RD_BURST.
REQ-019 In RD_BURST, read_o SHALL be 1, and address_o SHALL be the latched address.
REQ-020 On every RD_BURST cycle with resp_i=1, burst_i SHALL be stored into line bits [64k+63:64k], where k is the beat counter, and the counter SHALL increment; cycles with resp_i=0 SHALL neither store nor count.
REQ-021 In WR_BURST, write_o SHALL be 1, burst_o SHALL be latched-line bits [64k+63:64k], and k SHALL advance only on resp_i=1.
REQ-022 When resp_i=1 with k=3 in either burst state, the next state SHALL be DONE; the counter SHALL wrap to 0.
REQ-023 In DONE, resp_o SHALL be 1 for exactly one cycle, with line_o holding the complete line on a fill; the next state SHALL be IDLE unconditionally.
REQ-024 line_o SHALL hold its value until the next fill completes beat 0.
REQ-025 Latency SHALL be 1 cycle of acceptance, then 4 resp_i beats, then 1 DONE cycle; the minimum request-to-resp_o latency SHALL be 6 cycles.
REQ-026 read_i and write_i SHALL be ignored outside IDLE; a request still high in the cycle after DONE SHALL start a new transaction.
REQ-027 resp_i in IDLE or DONE SHALL be ignored.

Reset
REQ-028 While rst=1, the state SHALL be IDLE, the counter 0, read_o, write_o and resp_o 0, and burst_o, address_o and line_o all 0.
REQ-029 Reset asserted mid-burst SHALL abort immediately without a resp_o pulse; the partial line SHALL be discarded.

Configuration
REQ-030 With ADAPTOR_ALIGN_EN defined, address_o bits [4:0] SHALL be forced to 0 (32-byte line alignment); without it, address_o SHALL be the latched address_i verbatim.

Verification
REQ-031 Fill: read_i=1 at 0x0000_1040, resp_i on 4 consecutive cycles with beats 0x11..,0x22..,0x33..,0x44.. -> line_o={0x44..,0x33..,0x22..,0x11..}, one resp_o pulse, total latency 6 cycles.
REQ-032 Writeback: write_i=1, line_i=0xDDDD..CCCC..BBBB..AAAA.. -> burst_o sequence AAAA, BBBB, CCCC, DDDD on successive resp_i; write_o drops after DONE.
REQ-033 Gapped beats: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, and resp_o fires only after the 4th beat.
REQ-034 Simultaneous read_i=write_i=1 -> WR_BURST taken, and read_o stays 0.
REQ-035 rst pulse after beat 2 of a fill -> all outputs 0 asynchronously, no resp_o; a following fill completes correctly.
REQ-036 ADAPTOR_ALIGN_EN defined, address_i=0x0000_105F -> address_o=0x0000_1040; with it undefined -> 0x0000_105F.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Bridges a 256-bit cache line port to a 64-bit burst memory port.
// A fill gathers BEATS memory beats into line_o. A writeback serialises
// line_i onto burst_o. Each completed line produces one resp_o pulse.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   line_i / line_o   : cache-side writeback line / assembled fill line
//   address_i         : cache-side line address
//   read_i / write_i  : cache fill / writeback requests (write wins)
//   resp_o            : one-cycle line-complete pulse to the cache
//   burst_i / burst_o : memory read beat / memory write beat
//   address_o         : memory burst address
//   read_o / write_o  : memory burst read / write requests
//   resp_i            : memory beat valid / accepted strobe
//
// Build option
//   ADAPTOR_ALIGN_EN  : when defined, address_o[4:0] is forced to zero
//                       (32-byte line alignment)
//
// state    | meaning
// IDLE     | waiting for read_i / write_i
// RD_BURST | collecting memory beats into line_o
// WR_BURST | presenting latched line beats on burst_o
// DONE     | resp_o pulse, back to IDLE next cycle

module cacheline_adaptor #(
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*BEATS-1:0]   line_i,
    output logic [64*BEATS-1:0]   line_o,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [63:0]           burst_i,
    output logic [63:0]           burst_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [64*BEATS-1:0]   wline;
    logic [31:0]           addr_next;

`ifdef ADAPTOR_ALIGN_EN
    assign addr_next = {address_i[31:5], 5'b0};
`else
    assign addr_next = address_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wline     <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        state     <= WR_BURST;
                        address_o <= addr_next;
                        wline     <= line_i;
                        cnt       <= '0;
                        write_o   <= 1'b1;
                        // first beat is ready as soon as the burst starts
                        burst_o   <= line_i[63:0];
                    end else if (read_i) begin
                        state     <= RD_BURST;
                        address_o <= addr_next;
                        cnt       <= '0;
                        read_o    <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[64*int'(cnt) +: 64] <= burst_i;
                        if (cnt == LAST) begin
                            cnt    <= '0;
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        if (cnt == LAST) begin
                            cnt     <= '0;
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            // preload the beat for the next count value
                            burst_o <= wline[64*(int'(cnt) + 1) +: 64];
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor #(.BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;   // fill: beats {b3,b2,b1,b0}; writeback: line_i
        logic [7:0]   gaps;   // resp_i per burst cycle, LSB first, then all 1
        logic         noise;  // drive the other request during the burst
    } vec_t;

    typedef struct {
        logic         fill;
        logic [255:0] line;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    logic [255:0] last_fill = '0;
    vec_t        vecs[6];

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef ADAPTOR_ALIGN_EN
        return {a[31:5], 5'b0};
`else
        return a;
`endif
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard side: line completions and write beats as the DUT produces them
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_resp_o", 1'b1, 1'b0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.fill) chk("line_o", line_o, e.line);
                end
            end
            if (write_o && resp_i) begin
                if (wq.size() == 0) chk("spurious_write_beat", 1'b1, 1'b0);
                else chk("burst_o", {192'd0, burst_o}, {192'd0, wq.pop_front()});
            end
        end
    end

    task automatic run_txn(input vec_t v);
        logic fill;
        logic early;
        logic rd_in_wr;
        int   nb, cycles, gi, zeros;
        sb_t  e;
        fill      = v.rd && !v.wr;
        read_i    = v.rd;
        write_i   = v.wr;
        address_i = v.addr;
        line_i    = v.data;
        e.fill    = fill;
        e.line    = v.data;
        sb_q.push_back(e);
        if (!fill) for (int i = 0; i < 4; i++) wq.push_back(v.data[64*i +: 64]);
        @(posedge clk); #1;
        read_i  = v.noise && !fill;
        write_i = v.noise && fill;
        line_i  = ~v.data;
        chk("read_o_accept", read_o, fill);
        chk("write_o_accept", write_o, !fill);
        chk("address_o", address_o, exp_addr(v.addr));
        nb = 0; cycles = 1; gi = 0; zeros = 0; early = 0; rd_in_wr = 0;
        while (nb < 4 && cycles < 40) begin
            resp_i = (gi < 8) ? v.gaps[gi] : 1'b1;
            gi++;
            if (resp_i) begin
                burst_i = fill ? v.data[64*nb +: 64] : {$urandom, $urandom};
                nb++;
            end else begin
                burst_i = {$urandom, $urandom};
                zeros++;
            end
            @(posedge clk); #1;
            cycles++;
            if (nb < 4 && resp_o) early = 1;
            if (!fill && read_o) rd_in_wr = 1;
        end
        resp_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        chk("beat_budget", nb, 4);
        chk("early_resp_o", early, 1'b0);
        if (!fill) chk("read_o_during_write", rd_in_wr, 1'b0);
        chk("resp_o_done", resp_o, 1'b1);
        cycles++;
        chk("latency", cycles, 6 + zeros);
        if (fill) last_fill = v.data;
        @(posedge clk); #1;
        chk("resp_o_single", resp_o, 1'b0);
        chk("read_o_after", read_o, 1'b0);
        chk("write_o_after", write_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1040,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'hFF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2000,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 8'hFF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3008,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 8'hD9, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_4000,
                    {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                     64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888}, 8'hFF, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_105F,
                    {64'h9999_0000_9999_0000, 64'hAAAA_5555_AAAA_5555,
                     64'h1234_5678_1234_5678, 64'hCAFE_BABE_DEAD_BEEF}, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_6010,
                    {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                     64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 8'h5A, 1'b1};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = '0; burst_i = '0;
        #1;
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_line_o", line_o, 256'd0);
        chk("rst_address_o", address_o, 32'd0);
        chk("rst_burst_o", burst_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // resp_i with no transaction in flight must do nothing
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        chk("idle_read_o", read_o, 1'b0);
        chk("idle_write_o", write_o, 1'b0);
        chk("idle_resp_o", resp_o, 1'b0);
        chk("line_o_hold", line_o, last_fill);

        // reset after beat 2 of a fill: immediate abort, nothing reported
        read_i = 1'b1; address_i = 32'h0000_5000;
        @(posedge clk); #1;
        read_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = 64'hEEEE_0000_0000_0000 | 64'(i);
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_read_o", read_o, 1'b0);
        chk("abort_write_o", write_o, 1'b0);
        chk("abort_resp_o", resp_o, 1'b0);
        chk("abort_line_o", line_o, 256'd0);
        chk("abort_address_o", address_o, 32'd0);
        chk("abort_burst_o", burst_o, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        run_txn(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        chk("wq_empty", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
